key_filter: RTL and testbench
=============================

# key_filter

- Debounces a mechanical push-button and emits a single-cycle enable pulse per confirmed press.
- Sits directly upstream of the pulse-triggered counter stage and drives that stage's `en` input.
- Also provides a debounced level and a release pulse for other consumers on the same board clock (50 MHz, 20 ns).

## Interface

Parameters:

- `CNT_MAX`, default 1_000_000: number of consecutive stable cycles required to accept a transition (20 ms at 50 MHz). Must be ≥ 2.
- `KEY_ACTIVE`, default 1'b0: logic level of `key_in` when the button is pressed.

Ports:

- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `key_in`, input, 1: raw button, asynchronous to `clk`, bouncing.
- `key_flag`, output, 1: one-cycle pulse on a confirmed press. Connects to the downstream `en`.
- `key_rls`, output, 1: one-cycle pulse on a confirmed release.
- `key_state`, output, 1: debounced level; 1 = pressed.

## Operation

- **Synchronizer:** two flops on `key_in` produce `key_s`.
  - Both flops reset to `~KEY_ACTIVE` (released), so a reset never fabricates an edge.
- **"Pressed" definition:** `key_s == KEY_ACTIVE`.
- **FSM** (4 states, registered). `cnt` is a counter of width `$clog2(CNT_MAX)`.
  - **IDLE** (released): if pressed → FILTER_DN with `cnt <= 0`.
  - **FILTER_DN:**
    - if released → IDLE with `cnt <= 0` (bounce rejected);
    - else if `cnt == CNT_MAX-1` → DOWN with `key_flag <= 1`, `cnt <= 0`;
    - else `cnt <= cnt+1`.
  - **DOWN** (pressed): if released → FILTER_UP with `cnt <= 0`.
  - **FILTER_UP:**
    - if pressed → DOWN with `cnt <= 0`;
    - else if `cnt == CNT_MAX-1` → IDLE with `key_rls <= 1`, `cnt <= 0`;
    - else `cnt <= cnt+1`.
- **`key_flag` / `key_rls`:** registered, high for exactly one cycle, cleared on every other cycle. They are never high simultaneously.
- **`key_state`:** registered; 1 in DOWN and FILTER_UP, 0 in IDLE and FILTER_DN.
- **Counter:** `cnt` never exceeds `CNT_MAX-1`; no wrap. `cnt` is 0 in IDLE and DOWN.
- **Reset values** (synchronous, when `rst_n` is low at a clock edge): state = IDLE, `cnt = 0`, `key_flag = 0`, `key_rls = 0`, `key_state = 0`, sync flops released.
- **Reset mid-filter:** any partial count is discarded.
- **Button held through reset deassertion:** treated as a fresh press; a full `CNT_MAX` filter runs, then `key_flag` pulses once.
- **Held button:** produces exactly one `key_flag`; there is no auto-repeat.

## Timing

- **Press latency.** Let edge 0 be the first clock edge sampling `key_in` pressed, with `key_in` stable afterwards.
  - Edge 1: `key_s` becomes pressed.
  - Edge 2: FSM enters FILTER_DN.
  - Edge `CNT_MAX+2`: FSM enters DOWN and `key_flag` rises.
  - Edge `CNT_MAX+3`: `key_flag` falls.
  - `key_state` rises on the same edge as `key_flag`.
- **Release latency:** symmetric. `key_rls` rises `CNT_MAX+2` edges after the first sampled release; `key_state` falls on the same edge.
- **Glitch rejection:** a pressed interval sampled for fewer than `CNT_MAX+1` consecutive `key_s` cycles produces no pulse.
- **Bounce restart:** any bounce restarts the filter from 0.
- **Downstream timing:** the counter stage sees `en` high for exactly one `clk` period, aligned to the rising edge of `clk`. This matches the downstream stage's requirement.

## Structure

- **Shared package `key_pkg`:**
  - state encoding localparams `ST_IDLE = 2'd0`, `ST_FILTER_DN = 2'd1`, `ST_DOWN = 2'd2`, `ST_FILTER_UP = 2'd3`;
  - default `CNT_MAX_20MS = 1_000_000`.
- **Sub-module `sync_2ff`:**
  - parameterised reset value;
  - synchronous active-low reset;
  - reused by other asynchronous-input blocks.
- **Remainder:** FSM, counter and output registers live in a single always-block group inside `key_filter`.

## Test plan

All scenarios use `CNT_MAX = 10`, `KEY_ACTIVE = 0`, and a 20 ns clock.

1. **Reset:** hold `rst_n = 0` for 10 cycles with `key_in = 0` (pressed), then release reset → all outputs 0 during reset; `key_flag` pulses once, 12 cycles after the first post-reset sampling edge; `key_state = 1` thereafter.
2. **Clean press:** `key_in` goes 1→0 and is held for 50 cycles → exactly one `key_flag` pulse, one cycle wide, at edge 12; no `key_rls`.
3. **Bounce:** `key_in` toggles 0/1 every 3 cycles for 30 cycles, then stays 0 → no pulse during bouncing; a single `key_flag` 12 cycles after the last transition to 0.
4. **Short glitch:** `key_in` low for 8 cycles, then back to 1 → no `key_flag`, no `key_rls`, `key_state` stays 0.
5. **Release:** from DOWN, `key_in` goes to 1 and is held → `key_rls` pulses once at edge 12; `key_state` falls on that edge; `key_flag` stays 0.
6. **Reset mid-filter:** assert `rst_n = 0` for 1 cycle when `cnt = 5` in FILTER_DN → state IDLE, `cnt = 0`; with `key_in` still 0, the filter restarts and `key_flag` appears 12 cycles after reset deassertion, never earlier.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debounce path: FSM encoding,
// default filter length and the "pressed" helper.
package key_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_FILTER_DN = 2'd1;
  localparam logic [1:0] ST_DOWN      = 2'd2;
  localparam logic [1:0] ST_FILTER_UP = 2'd3;

  // 20 ms of stable input at a 50 MHz board clock
  localparam int CNT_MAX_20MS = 1_000_000;

  typedef enum logic [1:0] {
    FSM_IDLE      = ST_IDLE,
    FSM_FILTER_DN = ST_FILTER_DN,
    FSM_DOWN      = ST_DOWN,
    FSM_FILTER_UP = ST_FILTER_UP
  } key_fsm_e;

  function automatic logic is_pressed(input logic level, input logic active_level);
    return level == active_level;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable value
// loaded on synchronous active-low reset.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: synchronizes key_in, requires CNT_MAX stable cycles
// per transition and emits one-cycle press/release pulses plus a clean level.
module key_filter
  import key_pkg::*;
#(
  parameter int   CNT_MAX    = CNT_MAX_20MS,
  parameter logic KEY_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_rls,
  output logic key_state
);

  localparam int                CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic key_s;
  logic pressed;

  key_fsm_e         state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             key_flag_d, key_flag_q;
  logic             key_rls_d, key_rls_q;
  logic             key_state_d, key_state_q;

  // Reset to the released level so leaving reset never looks like an edge
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (~KEY_ACTIVE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_s)
  );

  assign pressed = is_pressed(key_s, KEY_ACTIVE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_flag_d = 1'b0;
    key_rls_d  = 1'b0;

    case (state_q)
      FSM_IDLE: begin
        if (pressed) begin
          state_d = FSM_FILTER_DN;
          cnt_d   = '0;
        end
      end

      // Any release while filtering is a bounce and restarts from IDLE
      FSM_FILTER_DN: begin
        if (!pressed) begin
          state_d = FSM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = FSM_DOWN;
          key_flag_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FSM_DOWN: begin
        if (!pressed) begin
          state_d = FSM_FILTER_UP;
          cnt_d   = '0;
        end
      end

      FSM_FILTER_UP: begin
        if (pressed) begin
          state_d = FSM_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = FSM_IDLE;
          key_rls_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = FSM_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the next state so it moves on the same edge as the pulses
    key_state_d = (state_d == FSM_DOWN) || (state_d == FSM_FILTER_UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FSM_IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      key_rls_q   <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_flag_q  <= key_flag_d;
      key_rls_q   <= key_rls_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_flag  = key_flag_q;
  assign key_rls   = key_rls_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: stimulus queues the expected pulse kind and
// clock edge, a negedge monitor pops and checks each pulse the DUT produces.
module tb_key_filter;

  localparam int CNT_MAX = 10;
  localparam int LAT     = CNT_MAX + 2;

  typedef enum int {K_FLAG, K_RLS} pulse_kind_e;

  typedef struct {
    pulse_kind_e kind;
    int          edge_no;
  } exp_pulse_t;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_rls;
  logic key_state;

  int edge_cnt = 0;
  int checks   = 0;
  int failures = 0;

  exp_pulse_t exp_q[$];

  key_filter #(
    .CNT_MAX    (CNT_MAX),
    .KEY_ACTIVE (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_rls   (key_rls),
    .key_state (key_state)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge just after driving key_in/rst_n: the next posedge is
  // the first sampling edge, and the pulse lands LAT edges after it.
  task automatic expect_pulse(input pulse_kind_e k);
    exp_pulse_t e;
    e.kind    = k;
    e.edge_no = edge_cnt + 1 + LAT;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic level, input bit has_pulse, input pulse_kind_e k);
    key_in = level;
    if (has_pulse) expect_pulse(k);
  endtask

  always @(negedge clk) begin
    exp_pulse_t e;
    if (key_flag || key_rls) begin
      check_output("pulses_exclusive", int'(key_flag && key_rls), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got flag=%0d rls=%0d expected none (edge %0d)",
                 key_flag, key_rls, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        check_output("pulse_kind", key_flag ? int'(K_FLAG) : int'(K_RLS), int'(e.kind));
        check_output("pulse_edge", edge_cnt, e.edge_no);
        check_output("pulse_level", int'(key_state), (e.kind == K_FLAG) ? 1 : 0);
      end
    end
  end

  initial begin
    // Scenario 1: button held pressed through reset
    key_in = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_output("reset_outputs", int'({key_flag, key_rls, key_state}), 0);
    end
    rst_n = 1'b1;
    expect_pulse(K_FLAG);
    step(30);
    check_output("held_through_reset_state", int'(key_state), 1);

    // Scenario 5: release from DOWN
    apply_stimulus(1'b1, 1'b1, K_RLS);
    step(30);
    check_output("release_state", int'(key_state), 0);

    // Scenario 2: clean press held 50 cycles, single flag, no repeat
    apply_stimulus(1'b0, 1'b1, K_FLAG);
    step(50);
    check_output("clean_press_state", int'(key_state), 1);
    apply_stimulus(1'b1, 1'b1, K_RLS);
    step(30);

    // Scenario 3: bounce every 3 cycles, then settle pressed
    for (int seg = 0; seg < 10; seg++) begin
      apply_stimulus((seg % 2 == 0) ? 1'b0 : 1'b1, 1'b0, K_FLAG);
      step(3);
      check_output("bounce_state", int'(key_state), 0);
    end
    apply_stimulus(1'b0, 1'b1, K_FLAG);
    step(30);
    check_output("bounce_settled_state", int'(key_state), 1);
    apply_stimulus(1'b1, 1'b1, K_RLS);
    step(30);

    // Scenario 4: 8-cycle glitch must be rejected
    apply_stimulus(1'b0, 1'b0, K_FLAG);
    step(8);
    check_output("glitch_state_mid", int'(key_state), 0);
    apply_stimulus(1'b1, 1'b0, K_FLAG);
    step(30);
    check_output("glitch_state_after", int'(key_state), 0);

    // Scenario 6: one-cycle reset when the filter count has reached 5
    apply_stimulus(1'b0, 1'b0, K_FLAG);
    step(8);
    rst_n = 1'b0;
    step(1);
    check_output("mid_filter_reset_outputs", int'({key_flag, key_rls, key_state}), 0);
    rst_n = 1'b1;
    expect_pulse(K_FLAG);
    step(30);
    check_output("after_mid_reset_state", int'(key_state), 1);
    apply_stimulus(1'b1, 1'b1, K_RLS);
    step(30);
    check_output("final_state", int'(key_state), 0);

    check_output("missing_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
